// File: rtl/timer_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : timer_ctrl_pkg
// Description : Shared definitions for the timer_ctrl compare/interrupt
//               scheduler: command opcodes, channel state, default width.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package timer_ctrl_pkg;

   // Default counter/deadline width; matches the free-running timer count.
   localparam int CW_DEFAULT = 32;

   // Configuration command opcodes carried on cfg_op.
   localparam logic [1:0] OP_ARM_ONESHOT  = 2'b00;
   localparam logic [1:0] OP_ARM_PERIODIC = 2'b01;
   localparam logic [1:0] OP_DISARM       = 2'b10;
   localparam logic [1:0] OP_CLEAR_PEND   = 2'b11;

   // Per-channel scheduling state.
   typedef enum logic [0:0] {
      CH_IDLE  = 1'b0,
      CH_ARMED = 1'b1
   } ch_state_e;

endpackage : timer_ctrl_pkg

`default_nettype wire

// File: rtl/timer_ctrl_cmp.sv
//------------------------------------------------------------------------------
// Module      : timer_ctrl_cmp
// Description : Shared expiry comparator. A deadline has expired when the
//               wrap-safe signed difference (count - deadline) is >= 0. Also
//               produces the next periodic deadline (old deadline + period)
//               so periodic channels never accumulate drift.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_ctrl_cmp #(
   parameter int CW = 32
) (
   input  logic [CW-1:0] i_count,
   input  logic [CW-1:0] i_deadline,
   input  logic [CW-1:0] i_period,
   output logic          o_expired,
   output logic [CW-1:0] o_next_deadline
);

   logic [CW-1:0] w_diff;

   // Modular difference; its sign bit tells whether count is past deadline.
   assign w_diff          = i_count - i_deadline;
   assign o_expired       = ~w_diff[CW-1];
   assign o_next_deadline = i_deadline + i_period;

endmodule : timer_ctrl_cmp

`default_nettype wire

// File: rtl/timer_ctrl.sv
//------------------------------------------------------------------------------
// Module      : timer_ctrl
// Description : Multi-channel compare/interrupt scheduler. Holds NCH armed
//               deadlines (one-shot or periodic) against the free-running
//               timer count and raises sticky per-channel pending flags. One
//               comparator is shared by a round-robin scan pointer.
// Options     : TIMER_CTRL_OVERRUN_EN - adds the overrun[NCH] output, set
//               when a channel expires while still pending, cleared by
//               CLEAR_PEND.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_ctrl
   import timer_ctrl_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = CW_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CW-1:0]            count,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [$clog2(NCH)-1:0]   cfg_ch,
   input  logic [1:0]               cfg_op,
   input  logic [CW-1:0]            cfg_data,
   output logic [NCH-1:0]           ch_active,
   output logic [NCH-1:0]           irq_pending,
   output logic                     irq
`ifdef TIMER_CTRL_OVERRUN_EN
   ,
   output logic [NCH-1:0]           overrun
`endif
);

   localparam int             PW         = $clog2(NCH);
   // ARM deltas are limited to half the counter range so the signed compare
   // stays unambiguous.
   localparam logic [CW-1:0]  DELTA_MASK = {1'b0, {(CW-1){1'b1}}};
   localparam logic [CW-1:0]  DELTA_MIN  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0]  PTR_LAST   = PW'(NCH - 1);
   localparam logic [PW:0]    NCH_EXT    = (PW + 1)'(NCH);

   // Channel storage
   ch_state_e       r_state    [NCH];
   logic [CW-1:0]   r_deadline [NCH];
   logic [CW-1:0]   r_period   [NCH];
   logic [NCH-1:0]  r_periodic;
   logic [NCH-1:0]  r_pending;
   logic [PW-1:0]   r_ptr;
   logic            r_irq;

   // Command path
   logic            w_accept;
   logic            w_ch_ok;
   logic            w_cmd;
   logic            w_is_arm;
   logic [CW-1:0]   w_delta_masked;
   logic [CW-1:0]   w_delta;
   logic [CW-1:0]   w_arm_deadline;

   // Scan path
   logic            w_collide;
   logic            w_expired;
   logic            w_scan_fire;
   logic [CW-1:0]   w_next_deadline;
   logic [PW-1:0]   w_ptr_next;

   assign cfg_ready      = ~reset;
   assign w_accept       = cfg_valid & cfg_ready;
   // Channel numbers beyond NCH-1 (non power-of-two NCH) are accepted but ignored.
   assign w_ch_ok        = ({1'b0, cfg_ch} < NCH_EXT);
   assign w_cmd          = w_accept & w_ch_ok;
   assign w_is_arm       = (cfg_op == OP_ARM_ONESHOT) | (cfg_op == OP_ARM_PERIODIC);

   assign w_delta_masked = cfg_data & DELTA_MASK;
   assign w_delta        = (w_delta_masked == '0) ? DELTA_MIN : w_delta_masked;
   assign w_arm_deadline = count + w_delta;

   // A command on the channel under the scan pointer wins; that channel is
   // simply re-examined on the next round.
   assign w_collide      = w_cmd & (cfg_ch == r_ptr);
   assign w_ptr_next     = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;

   timer_ctrl_cmp #(
      .CW (CW)
   ) u_cmp (
      .i_count         (count),
      .i_deadline      (r_deadline[r_ptr]),
      .i_period        (r_period[r_ptr]),
      .o_expired       (w_expired),
      .o_next_deadline (w_next_deadline)
   );

   assign w_scan_fire = (r_state[r_ptr] == CH_ARMED) & w_expired & ~w_collide;

   // Scan pointer, per-channel state, command application and registered irq
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr      <= '0;
         r_irq      <= 1'b0;
         r_periodic <= '0;
         r_pending  <= '0;
         for (int i = 0; i < NCH; i++) begin
            r_state[i]    <= CH_IDLE;
            r_deadline[i] <= '0;
            r_period[i]   <= '0;
         end
      end else begin
         r_ptr <= w_ptr_next;
         r_irq <= |r_pending;

         if (w_scan_fire) begin
            r_pending[r_ptr] <= 1'b1;
            if (r_periodic[r_ptr]) begin
               r_deadline[r_ptr] <= w_next_deadline;
            end else begin
               r_state[r_ptr] <= CH_IDLE;
            end
         end

         if (w_cmd) begin
            if (w_is_arm) begin
               r_state[cfg_ch]    <= CH_ARMED;
               r_deadline[cfg_ch] <= w_arm_deadline;
               r_period[cfg_ch]   <= w_delta;
               r_periodic[cfg_ch] <= (cfg_op == OP_ARM_PERIODIC);
            end else if (cfg_op == OP_DISARM) begin
               r_state[cfg_ch] <= CH_IDLE;
            end else begin
               r_pending[cfg_ch] <= 1'b0;
            end
         end
      end
   end

   // Expose the ARMED state of every channel
   always_comb begin
      ch_active = '0;
      for (int i = 0; i < NCH; i++) begin
         ch_active[i] = (r_state[i] == CH_ARMED);
      end
   end

   assign irq_pending = r_pending;
   assign irq         = r_irq;

`ifdef TIMER_CTRL_OVERRUN_EN
   logic [NCH-1:0] r_overrun;

   // Flag expiries that land on a channel whose previous expiry is unserviced
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overrun <= '0;
      end else begin
         if (w_scan_fire && r_pending[r_ptr]) begin
            r_overrun[r_ptr] <= 1'b1;
         end
         if (w_cmd && (cfg_op == OP_CLEAR_PEND)) begin
            r_overrun[cfg_ch] <= 1'b0;
         end
      end
   end

   assign overrun = r_overrun;
`endif

endmodule : timer_ctrl

`default_nettype wire
